// File: rtl/cheri_pkg.sv
// Shared types for the data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: mem_resp_t, the entry carried down the response pipe.
package cheri_pkg;

  localparam int unsigned CapW = 33;

  // One queued bus response: 33-bit read data (bit 32 = tag) plus error flag.
  typedef struct packed {
    logic [CapW-1:0] rdata;
    logic            err;
  } mem_resp_t;

endpackage

// File: rtl/ibexc_data_mem_responder_if.sv
// Data-bus bundle between the core's data initiator and the memory responder.
// Latency: n/a (wires only).
// Backpressure: gnt from the responder; responses cannot be refused.
//
// master: core side (drives req/we/be/addr/is_cap/wdata).
// slave : responder side (drives gnt/rvalid/rdata/rdata_intg/err).
interface ibexc_data_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic        data_is_cap_i;
  logic [32:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [32:0] data_rdata_o;
  logic [6:0]  data_rdata_intg_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_is_cap_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_is_cap_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o
  );
endinterface

// File: rtl/ibexc_data_mem_responder_resp_pipe.sv
// Fixed-depth valid/data shift register carrying bus responses.
// Latency: Depth cycles from i_vld to o_vld.
// Backpressure: none; an entry leaves after exactly Depth cycles.
//
// clk_i/rst_i (sync, active-high), i_vld/i_dat in, o_vld/o_dat out.
module ibexc_resp_pipe
  import cheri_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      i_vld,
  input  mem_resp_t i_dat,
  output logic      o_vld,
  output mem_resp_t o_dat
);
  logic [Depth-1:0] r_vld;
  mem_resp_t        r_dat [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int i = 0; i < Depth; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_dat[0] <= i_dat;
      for (int i = 1; i < Depth; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld = r_vld[Depth-1];
  assign o_dat = r_dat[Depth-1];
endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted SECDED(39,32) encoder: appends 7 check bits, a fixed pattern inverted.
// Latency: combinational.
// Backpressure: none.
//
// data_i [31:0] in, data_o [38:0] out ({check, data}).
module prim_secded_inv_39_32_enc (
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);
  logic [6:0] w_chk;

  assign w_chk[0] = ^(data_i & 32'h2606_BD25);
  assign w_chk[1] = ^(data_i & 32'hDEBA_8050);
  assign w_chk[2] = ^(data_i & 32'h413D_89AA);
  assign w_chk[3] = ^(data_i & 32'h3123_4ED1);
  assign w_chk[4] = ^(data_i & 32'hC2C1_323B);
  assign w_chk[5] = ^(data_i & 32'h2DCC_624C);
  assign w_chk[6] = ^(data_i & 32'h9850_5586);

  // Inversion keeps an all-zero word from encoding to all-zero check bits.
  assign data_o = {w_chk ^ 7'h2A, data_i};
endmodule

// File: rtl/ibexc_data_mem_responder.sv
// Tagged 33-bit data memory answering the core's req/gnt data bus, in order.
// Latency: RespLatency cycles from accept to rvalid.
// Backpressure: gnt drops on stall_i or when MaxOutst responses are pending.
//
// Ports: clk_i, rst_i (sync active-high), stall_i, bus (slave modport),
//        req_cnt_o / err_cnt_o saturating accept / error-response counters.
module ibexc_data_mem_responder
  import cheri_pkg::*;
#(
  parameter logic [31:0] AddrBase    = 32'h8000_0000,
  parameter int unsigned DepthWords  = 4096,
  parameter int unsigned RespLatency = 1,
  parameter int unsigned MaxOutst    = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        stall_i,
  ibexc_data_mem_responder_if.slave   bus,
  output logic [15:0]                 req_cnt_o,
  output logic [15:0]                 err_cnt_o
);
  localparam int unsigned IdxW = $clog2(DepthWords);
  localparam logic [32:0] AddrLimit = {1'b0, AddrBase} + 33'(64'(DepthWords) * 4);

  // Out of range on either side, or not word aligned.
  function automatic logic addr_bad(input logic [31:0] a);
    return ({1'b0, a} < {1'b0, AddrBase}) || ({1'b0, a} >= AddrLimit) || (a[1:0] != 2'b00);
  endfunction

  logic [32:0]     r_mem [DepthWords];
  logic [2:0]      r_outst;
  logic [15:0]     r_req_cnt;
  logic [15:0]     r_err_cnt;

  logic            w_resp_vld;
  mem_resp_t       w_resp;
  mem_resp_t       w_req_resp;
  logic [2:0]      w_outst_free;
  logic            w_acc;
  logic            w_err;
  logic [IdxW-1:0] w_idx;
  logic [32:0]     w_word;
  logic [32:0]     w_wr_word;
  logic            w_wr_en;
  logic [38:0]     w_enc;

  // A response leaving this cycle frees its slot for this cycle's grant.
  assign w_outst_free   = r_outst - {2'b00, w_resp_vld};
  assign bus.data_gnt_o = bus.data_req_i & ~stall_i & (w_outst_free < 3'(MaxOutst));
  assign w_acc          = bus.data_req_i & bus.data_gnt_o;

  assign w_err   = addr_bad(bus.data_addr_i);
  assign w_idx   = IdxW'((bus.data_addr_i - AddrBase) >> 2);
  assign w_word  = r_mem[w_idx];
  assign w_wr_en = w_acc & bus.data_we_i & ~w_err;

  // Read data is taken from the array before this cycle's write lands.
  always_comb begin
    w_req_resp     = '0;
    w_req_resp.err = w_err;
    if (!w_err && !bus.data_we_i) begin
      w_req_resp.rdata = {bus.data_is_cap_i & w_word[32], w_word[31:0]};
    end
  end

  // Only a full-word capability store can leave the tag set.
  always_comb begin
    w_wr_word = w_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.data_be_i[b]) w_wr_word[8*b +: 8] = bus.data_wdata_i[8*b +: 8];
    end
    w_wr_word[32] = bus.data_is_cap_i & (bus.data_be_i == 4'hF) & bus.data_wdata_i[32];
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_idx] <= w_wr_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst   <= '0;
      r_req_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_outst <= w_outst_free + {2'b00, w_acc};
      if (w_acc && (r_req_cnt != 16'hFFFF)) r_req_cnt <= r_req_cnt + 16'd1;
      if (w_resp_vld && w_resp.err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  ibexc_resp_pipe #(
    .Depth (RespLatency)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_vld (w_acc),
    .i_dat (w_req_resp),
    .o_vld (w_resp_vld),
    .o_dat (w_resp)
  );

  prim_secded_inv_39_32_enc u_enc (
    .data_i (w_resp.rdata[31:0]),
    .data_o (w_enc)
  );

  assign bus.data_rvalid_o     = w_resp_vld;
  assign bus.data_rdata_o      = w_resp.rdata;
  assign bus.data_err_o        = w_resp.err;
  assign bus.data_rdata_intg_o = w_enc[38:32];
  assign req_cnt_o             = r_req_cnt;
  assign err_cnt_o             = r_err_cnt;
endmodule

// File: tb/tb_ibexc_data_mem_responder.sv
// Bench for ibexc_data_mem_responder: directed cases plus random traffic
// checked every cycle against a queue-based reference model.
module tb_ibexc_data_mem_responder;
  import cheri_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 3;
  localparam int          MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [15:0] req_cnt;
  logic [15:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  ibexc_data_mem_responder_if bus();

  ibexc_data_mem_responder #(
    .AddrBase    (BASE),
    .DepthWords  (DEPTH),
    .RespLatency (LAT),
    .MaxOutst    (MAXO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .stall_i   (stall),
    .bus       (bus),
    .req_cnt_o (req_cnt),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc_ref(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  p;
    m[0] = 32'h2606_BD25; m[1] = 32'hDEBA_8050; m[2] = 32'h413D_89AA;
    m[3] = 32'h3123_4ED1; m[4] = 32'hC2C1_323B; m[5] = 32'h2DCC_624C;
    m[6] = 32'h9850_5586;
    for (int k = 0; k < 7; k++) begin
      p[k] = 1'b0;
      for (int j = 0; j < 32; j++) p[k] = p[k] ^ (d[j] & m[k][j]);
    end
    return p ^ 7'h2A;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [32:0] rd;
    logic        er;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [32:0] mmem [DEPTH];
  int          cyc = 0;
  int          m_outst = 0;
  int          m_req_cnt = 0;
  int          m_err_cnt = 0;
  bit          exp_rv;
  bit          exp_gnt;
  longint      a;
  int          idx;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_outst   = 0;
      m_req_cnt = 0;
      m_err_cnt = 0;
    end else begin
      exp_rv  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      exp_gnt = bus.data_req_i && !stall && ((m_outst - (exp_rv ? 1 : 0)) < MAXO);
      chk("gnt", bus.data_gnt_o, exp_gnt);
      chk("rvalid", bus.data_rvalid_o, exp_rv);
      chk("req_cnt", req_cnt, m_req_cnt);
      chk("err_cnt", err_cnt, m_err_cnt);
      if (exp_rv) begin
        e = exp_q.pop_front();
        chk("rdata", bus.data_rdata_o, e.rd);
        chk("err", bus.data_err_o, e.er);
        chk("intg", bus.data_rdata_intg_o, enc_ref(e.rd[31:0]));
        m_outst--;
        if (e.er && m_err_cnt < 65535) m_err_cnt++;
      end
      if (bus.data_req_i && exp_gnt) begin
        a    = longint'(bus.data_addr_i);
        e.due = cyc + LAT;
        e.rd = '0;
        e.er = (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH) ||
               (bus.data_addr_i[1:0] != 2'b00);
        if (!e.er) begin
          idx = int'((a - longint'(BASE)) / 4);
          if (bus.data_we_i) begin
            for (int b = 0; b < 4; b++)
              if (bus.data_be_i[b]) mmem[idx][8*b +: 8] = bus.data_wdata_i[8*b +: 8];
            mmem[idx][32] = bus.data_is_cap_i && (bus.data_be_i == 4'hF) && bus.data_wdata_i[32];
          end else begin
            e.rd = {bus.data_is_cap_i & mmem[idx][32], mmem[idx][31:0]};
          end
        end
        exp_q.push_back(e);
        m_outst++;
        if (m_req_cnt < 65535) m_req_cnt++;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic cap, input logic [32:0] wd,
                        output logic [32:0] rd, output logic er, output int lat);
    bit ok;
    @(posedge clk); #1;
    bus.data_req_i = 1'b1; bus.data_we_i = we; bus.data_be_i = be;
    bus.data_addr_i = addr; bus.data_is_cap_i = cap; bus.data_wdata_i = wd;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.data_gnt_o) begin ok = 1; break; end
    end
    if (!ok) chk("gnt_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.data_req_i = 1'b0;
    ok = 0; lat = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      lat++;
      if (bus.data_rvalid_o) begin ok = 1; break; end
    end
    if (!ok) chk("rvalid_timeout", 1'b0, 1'b1);
    rd = bus.data_rdata_o;
    er = bus.data_err_o;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 15))
      0:       return BASE - 32'd4;
      1:       return BASE + 32'(4 * DEPTH);
      2:       return BASE + 32'(4 * DEPTH - 4);
      3:       return BASE + 32'($urandom_range(1, 3));
      4:       return 32'hFFFF_FFFC;
      5:       return 32'h0;
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  logic [32:0] rd;
  logic        er;
  int          lat;
  logic [3:0]  gp;

  initial begin
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_be_i = 4'h0;
    bus.data_addr_i = '0; bus.data_is_cap_i = 1'b0; bus.data_wdata_i = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", bus.data_rdata_o, 33'h0);
    chk("rst_err", bus.data_err_o, 1'b0);
    chk("rst_intg", bus.data_rdata_intg_o, enc_ref(32'h0));
    chk("rst_rvalid", bus.data_rvalid_o, 1'b0);
    chk("rst_req_cnt", req_cnt, 16'h0);
    chk("rst_err_cnt", err_cnt, 16'h0);

    // Give every word a defined value.
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, 4'hF, BASE + 32'(4 * i), 1'($urandom), {1'($urandom), 32'($urandom)}, rd, er, lat);

    // Capability write/read and tag behaviour.
    do_req(1'b1, 4'hF, BASE + 32'd8, 1'b1, 33'h1_DEAD_BEEF, rd, er, lat);
    chk("wr_rdata", rd, 33'h0);
    chk("wr_lat", lat, LAT);
    do_req(1'b0, 4'hF, BASE + 32'd8, 1'b1, 33'h0, rd, er, lat);
    chk("cap_rd", rd, 33'h1_DEAD_BEEF);
    chk("cap_rd_err", er, 1'b0);
    do_req(1'b0, 4'hF, BASE + 32'd8, 1'b0, 33'h0, rd, er, lat);
    chk("nocap_rd", rd, 33'h0_DEAD_BEEF);
    do_req(1'b1, 4'b0001, BASE + 32'd8, 1'b1, 33'h1_0000_0055, rd, er, lat);
    do_req(1'b0, 4'hF, BASE + 32'd8, 1'b1, 33'h0, rd, er, lat);
    chk("tag_clear", rd, 33'h0_DEAD_BE55);

    // Error accesses.
    do_req(1'b0, 4'hF, BASE - 32'd4, 1'b1, 33'h0, rd, er, lat);
    chk("below_err", er, 1'b1);
    chk("below_rdata", rd, 33'h0);
    chk("below_lat", lat, LAT);
    @(negedge clk);
    chk("below_err_cnt", err_cnt, 16'd1);
    do_req(1'b0, 4'hF, BASE + 32'd2, 1'b0, 33'h0, rd, er, lat);
    chk("misal_err", er, 1'b1);
    chk("misal_rdata", rd, 33'h0);
    do_req(1'b1, 4'hF, BASE + 32'd10, 1'b1, 33'h1_1234_5678, rd, er, lat);
    chk("misal_wr_err", er, 1'b1);
    do_req(1'b0, 4'hF, BASE + 32'(4 * DEPTH), 1'b0, 33'h0, rd, er, lat);
    chk("above_err", er, 1'b1);
    do_req(1'b0, 4'hF, BASE + 32'(4 * DEPTH - 4), 1'b0, 33'h0, rd, er, lat);
    chk("top_word_ok", er, 1'b0);
    do_req(1'b0, 4'hF, BASE + 32'd8, 1'b1, 33'h0, rd, er, lat);
    chk("mem_unchanged", rd, 33'h0_DEAD_BE55);
    @(negedge clk);
    chk("err_cnt_total", err_cnt, 16'd4);

    // Back-pressure from outstanding limit with req held high.
    @(posedge clk); #1;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = BASE; bus.data_be_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      gp[c] = bus.data_gnt_o;
      @(posedge clk); #1;
      bus.data_addr_i = BASE + 32'(4 * (c + 1));
    end
    bus.data_req_i = 1'b0;
    chk("bp_gnt_pattern", gp, 4'b1011);
    repeat (8) @(posedge clk);

    // Stall holds off grants.
    #1 stall = 1'b1; bus.data_req_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_gnt", bus.data_gnt_o, 1'b0);
      @(posedge clk); #1;
    end
    stall = 1'b0; bus.data_req_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with two reads in flight.
    #1 bus.data_req_i = 1'b1; bus.data_addr_i = BASE + 32'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.data_req_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.data_req_i = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", bus.data_rvalid_o, 1'b0);
    chk("post_rst_gnt", bus.data_gnt_o, 1'b1);
    @(posedge clk); #1;
    bus.data_req_i = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid2", bus.data_rvalid_o, 1'b0);
    chk("post_rst_req_cnt", req_cnt, 16'd1);
    repeat (6) @(posedge clk);

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #1;
      bus.data_req_i    = ($urandom_range(0, 9) < 7);
      stall             = ($urandom_range(0, 9) < 2);
      bus.data_we_i     = 1'($urandom);
      bus.data_be_i     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      bus.data_is_cap_i = 1'($urandom);
      bus.data_wdata_i  = {1'($urandom), 32'($urandom)};
      bus.data_addr_i   = pick_addr();
    end
    @(posedge clk); #1;
    bus.data_req_i = 1'b0; stall = 1'b0;
    repeat (10) @(posedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
